// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and the future transmitter.
//   OVERSAMPLE          ticks per bit period
//   PAR_NONE/EVEN/ODD   parity selection encoding
//   rx_state_e          receiver state encoding
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRKWAIT
    } rx_state_e;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..DIVISOR-1 and asserts tick for one
// clock when the count reaches DIVISOR-1.
//   clock  in   system clock
//   reset  in   asynchronous, active-low
//   tick   out  one-cycle pulse every DIVISOR clocks
module uart_os_tick #(
    parameter int DIVISOR = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable 16x-oversampling UART receiver with valid/ready word output.
//   clock       in   system clock
//   reset       in   asynchronous, active-low
//   rxd         in   serial line, idle high, asynchronous
//   rx_data     out  received word, LSB = first data bit
//   rx_valid    out  word and status flags valid
//   rx_ready    in   consumer accepts the word
//   parity_err  out  parity mismatch for the held word
//   frame_err   out  a stop bit was sampled low
//   break_det   out  all data/parity/stop samples were low
//   overrun     out  one-cycle pulse when a completed frame is dropped
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | line idle, looking for a low sample on each tick
// ST_START   | confirming the start bit at its midpoint
// ST_DATA    | sampling DATA_BITS data bits, LSB first
// ST_PARITY  | sampling and checking the parity bit
// ST_STOP    | sampling STOP_BITS stop bits, then delivering the word
// ST_BRKWAIT | break seen, waiting for the line to return high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DIVISOR   = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);
    localparam logic       ODD_PAR   = (PARITY == PAR_ODD);

    logic tick;

    uart_os_tick #(.DIVISOR(DIVISOR)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    logic [1:0]           sync_q,       sync_d;
    rx_state_e            state_q,      state_d;
    logic [3:0]           sc_q,         sc_d;
    logic [3:0]           bit_q,        bit_d;
    logic                 stop_q,       stop_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 par_bad_q,    par_bad_d;
    logic                 stop_bad_q,   stop_bad_d;
    logic                 all_low_q,    all_low_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 break_det_q,  break_det_d;
    logic                 overrun_q,    overrun_d;

    logic rxs;
    logic mid;
    logic complete;

    always_comb begin
        sync_d       = {sync_q[0], rxd};
        rxs          = sync_q[1];
        mid          = tick && (sc_q == 4'd15);
        complete     = 1'b0;

        state_d      = state_q;
        sc_d         = tick ? sc_q + 4'd1 : sc_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        all_low_d    = all_low_q;

        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && !rxs) begin
                    sc_d       = '0;
                    bit_d      = '0;
                    stop_d     = 1'b0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    all_low_d  = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick && (sc_q == 4'd7)) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        sc_d    = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    all_low_d = all_low_q & ~rxs;
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (mid) begin
                    // Mismatch when the line bit differs from the expected
                    // parity: XOR of data (even) or its inverse (odd).
                    par_bad_d = rxs ^ (^shift_q) ^ ODD_PAR;
                    all_low_d = all_low_q & ~rxs;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid) begin
                    stop_bad_d = stop_bad_q | ~rxs;
                    all_low_d  = all_low_q & ~rxs;
                    stop_d     = 1'b1;
                    if (stop_q == STOP_LAST) begin
                        complete = 1'b1;
                        state_d  = all_low_d ? ST_BRKWAIT : ST_IDLE;
                    end
                end
            end
            ST_BRKWAIT: begin
                if (tick && rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A held word is only replaced when it is free or being taken
        // this very cycle; otherwise the new frame is dropped.
        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = all_low_d ? '0 : shift_q;
                parity_err_d = par_bad_d;
                frame_err_d  = stop_bad_d;
                break_det_d  = all_low_d;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            sc_q         <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            all_low_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            all_low_q    <= all_low_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule
